// File: rtl/hist_bank_ctrl.sv
// Histogram bank controller: NUM_BANKS dual-port RAM banks with a forwarded
// read-modify-write increment pipeline, shared-address read taps and a masked clear sequencer.
module hist_bank_ctrl #(
    parameter int NUM_BANKS = 32,
    parameter int BANK_W    = 5,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int NUM_RD    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inc_valid,
    input  logic [BANK_W-1:0]        inc_bank,
    input  logic [ADDR_W-1:0]        inc_addr,
    output logic                     inc_ready,
    input  logic                     wr_valid,
    input  logic [BANK_W-1:0]        wr_bank,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    input  logic [NUM_RD*BANK_W-1:0] rd_bank,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     rd_valid,
    input  logic                     clr_start,
    input  logic [NUM_BANKS-1:0]     clr_mask,
    output logic                     clr_busy,
    output logic                     clr_done,
    output logic                     sat_flag
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [BANK_W:0] LP_NB = (BANK_W+1)'(NUM_BANKS);

    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_CLEAR, ST_DONE} state_t;

    state_t                  r_state;
    logic [NUM_BANKS-1:0]    r_clr_mask;
    logic [ADDR_W-1:0]       r_clr_addr;

    logic [DATA_W-1:0]       r_mem [NUM_BANKS][DEPTH];
    logic [DATA_W-1:0]       r_qa  [NUM_BANKS];

    logic                    r_s1_valid;
    logic [BANK_W-1:0]       r_s1_bank;
    logic [ADDR_W-1:0]       r_s1_addr;
    logic                    r_s2_valid;
    logic [BANK_W-1:0]       r_s2_bank;
    logic [ADDR_W-1:0]       r_s2_addr;
    logic [DATA_W-1:0]       r_s2_data;
    logic                    r_wp_valid;
    logic [BANK_W-1:0]       r_wp_bank;
    logic [ADDR_W-1:0]       r_wp_addr;
    logic [DATA_W-1:0]       r_wp_data;

    logic                    r_rd_p1;
    logic [NUM_RD*BANK_W-1:0] r_rd_bank;

    logic                    w_inc_acc;
    logic                    w_clr_acc;
    logic                    w_pb_we;
    logic [ADDR_W-1:0]       w_a_raddr;
    logic [DATA_W-1:0]       w_old;
    logic [DATA_W-1:0]       w_new;
    logic                    w_sat;
    logic [BANK_W-1:0]       w_tap_bank;
    logic [NUM_RD*DATA_W-1:0] w_tap_data;

    function automatic logic f_bank_ok(input logic [BANK_W-1:0] b);
        return {1'b0, b} < LP_NB;
    endfunction

    assign inc_ready = (r_state == ST_IDLE) && !rd_en && !clr_start;
    assign w_inc_acc = inc_valid && inc_ready;
    assign w_clr_acc = (r_state == ST_IDLE) && clr_start;
    assign w_pb_we   = wr_valid && (r_state != ST_CLEAR);
    assign w_a_raddr = rd_en ? rd_addr : inc_addr;

    // RAM read of this S1 entry missed the two most recent write-backs; pick them up here
    always_comb begin
        w_old = r_qa[r_s1_bank];
        if (r_s2_valid && r_s2_bank == r_s1_bank && r_s2_addr == r_s1_addr)
            w_old = r_s2_data;
        else if (r_wp_valid && r_wp_bank == r_s1_bank && r_wp_addr == r_s1_addr)
            w_old = r_wp_data;
        w_sat = (w_old == '1);
        w_new = w_sat ? w_old : w_old + 1'b1;
    end

    always_comb begin
        w_tap_data = '0;
        w_tap_bank = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            w_tap_bank = r_rd_bank[i*BANK_W +: BANK_W];
            if (f_bank_ok(w_tap_bank))
                w_tap_data[i*DATA_W +: DATA_W] = r_qa[w_tap_bank];
        end
    end

    // Port B assignment comes last so it wins a same-cell collision with the write-back
    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < NUM_BANKS; b++)
            r_qa[b] <= r_mem[b][w_a_raddr];
        if (!rst) begin
            if (r_s2_valid && f_bank_ok(r_s2_bank))
                r_mem[r_s2_bank][r_s2_addr] <= r_s2_data;
            if (w_pb_we && f_bank_ok(wr_bank))
                r_mem[wr_bank][wr_addr] <= wr_data;
            if (r_state == ST_CLEAR) begin
                for (int unsigned b = 0; b < NUM_BANKS; b++)
                    if (r_clr_mask[b])
                        r_mem[b][r_clr_addr] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_clr_mask <= '0;
            r_clr_addr <= '0;
            r_s1_valid <= 1'b0;
            r_s1_bank  <= '0;
            r_s1_addr  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_bank  <= '0;
            r_s2_addr  <= '0;
            r_s2_data  <= '0;
            r_wp_valid <= 1'b0;
            r_wp_bank  <= '0;
            r_wp_addr  <= '0;
            r_wp_data  <= '0;
            r_rd_p1    <= 1'b0;
            r_rd_bank  <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            clr_busy   <= 1'b0;
            clr_done   <= 1'b0;
            sat_flag   <= 1'b0;
        end else begin
            r_s1_valid <= w_inc_acc;
            r_s1_bank  <= inc_bank;
            r_s1_addr  <= inc_addr;
            r_s2_valid <= r_s1_valid;
            r_s2_bank  <= r_s1_bank;
            r_s2_addr  <= r_s1_addr;
            r_s2_data  <= w_new;
            r_wp_valid <= r_s2_valid;
            r_wp_bank  <= r_s2_bank;
            r_wp_addr  <= r_s2_addr;
            r_wp_data  <= r_s2_data;

            if (w_clr_acc)
                sat_flag <= 1'b0;
            else if (r_s1_valid && w_sat)
                sat_flag <= 1'b1;

            r_rd_p1   <= rd_en;
            r_rd_bank <= rd_bank;
            rd_valid  <= r_rd_p1;
            if (r_rd_p1)
                rd_data <= w_tap_data;

            case (r_state)
                ST_IDLE: begin
                    if (clr_start) begin
                        r_state    <= ST_DRAIN;
                        r_clr_mask <= clr_mask;
                        clr_busy   <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!r_s1_valid && !r_s2_valid) begin
                        r_state    <= ST_CLEAR;
                        r_clr_addr <= '0;
                        r_wp_valid <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (r_clr_addr == '1) begin
                        r_state  <= ST_DONE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state  <= ST_IDLE;
                    clr_done <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hist_bank_ctrl.sv
// Self-checking bench for hist_bank_ctrl: reference bin model, read scoreboard,
// table-driven tap vectors and hand-written clear/reset sequences.
module tb_hist_bank_ctrl;
    localparam int NB = 32;
    localparam int BW = 5;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int NR = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             inc_valid;
    logic [BW-1:0]    inc_bank;
    logic [AW-1:0]    inc_addr;
    logic             inc_ready;
    logic             wr_valid;
    logic [BW-1:0]    wr_bank;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [NR*BW-1:0] rd_bank;
    logic [NR*DW-1:0] rd_data;
    logic             rd_valid;
    logic             clr_start;
    logic [NB-1:0]    clr_mask;
    logic             clr_busy;
    logic             clr_done;
    logic             sat_flag;

    hist_bank_ctrl #(.NUM_BANKS(NB), .BANK_W(BW), .ADDR_W(AW), .DATA_W(DW), .NUM_RD(NR)) dut (
        .clk(clk), .rst(rst),
        .inc_valid(inc_valid), .inc_bank(inc_bank), .inc_addr(inc_addr), .inc_ready(inc_ready),
        .wr_valid(wr_valid), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_bank(rd_bank), .rd_data(rd_data), .rd_valid(rd_valid),
        .clr_start(clr_start), .clr_mask(clr_mask), .clr_busy(clr_busy), .clr_done(clr_done),
        .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] model [NB][256];

    typedef struct {
        int            exp_cyc;
        logic [NR*DW-1:0] data;
    } sb_t;
    sb_t sb[$];

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [NR*BW-1:0] banks;
        logic [NR*DW-1:0] exp;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic chk_range(input string nm, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one tap read; expectation is due on rd_valid two cycles later
    task automatic issue_read(input logic [AW-1:0] a, input logic [NR*BW-1:0] banks,
                              input logic [NR*DW-1:0] exp);
        rd_en   = 1'b1;
        rd_addr = a;
        rd_bank = banks;
        sb.push_back('{exp_cyc: cyc + 2, data: exp});
        #1;
        chk("inc_ready_during_rd", {63'd0, inc_ready}, 64'd0);
        step();
    endtask

    task automatic model_read(input logic [AW-1:0] a, input logic [BW-1:0] b0,
                              input logic [BW-1:0] b1, input logic [BW-1:0] b2,
                              input logic [BW-1:0] b3);
        issue_read(a, {b3, b2, b1, b0}, {model[b3][a], model[b2][a], model[b1][a], model[b0][a]});
    endtask

    task automatic inc(input logic [BW-1:0] b, input logic [AW-1:0] a);
        inc_valid = 1'b1;
        inc_bank  = b;
        inc_addr  = a;
        if (model[b][a] != 16'hFFFF) model[b][a] = model[b][a] + 16'd1;
        #1;
        chk("inc_ready_idle", {63'd0, inc_ready}, 64'd1);
        step();
    endtask

    task automatic pb_write(input logic [BW-1:0] b, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_valid = 1'b1;
        wr_bank  = b;
        wr_addr  = a;
        wr_data  = d;
        model[b][a] = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && sb.size() > 0; i++) step();
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (rd_valid) begin
            if (sb.size() == 0) begin
                chk("rd_valid_unexpected", {63'd0, rd_valid}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("rd_valid_latency", 64'(cyc), 64'(e.exp_cyc));
                chk("tap_data", rd_data, e.data);
            end
        end else if (sb.size() > 0 && sb[0].exp_cyc <= cyc) begin
            chk("rd_valid_missing", {63'd0, rd_valid}, 64'd1);
            void'(sb.pop_front());
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int nb, nd, last_b, done_i, seen;
        logic [NR*DW-1:0] last_exp;

        tbl[0] = '{addr: 8'h40, banks: {5'd0, 5'd5, 5'd17, 5'd31},
                   exp: {16'h1111, 16'h2222, 16'h3333, 16'h4444}};
        tbl[1] = '{addr: 8'h40, banks: {5'd31, 5'd17, 5'd5, 5'd0},
                   exp: {16'h4444, 16'h3333, 16'h2222, 16'h1111}};
        tbl[2] = '{addr: 8'h40, banks: {5'd31, 5'd31, 5'd2, 5'd1},
                   exp: {16'h4444, 16'h4444, 16'h0000, 16'h5555}};
        tbl[3] = '{addr: 8'h7F, banks: {5'd4, 5'd1, 5'd3, 5'd3},
                   exp: {16'h0000, 16'h0000, 16'h0007, 16'h0007}};
        tbl[4] = '{addr: 8'h0A, banks: {5'd1, 5'd3, 5'd0, 5'd1},
                   exp: {16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF}};
        tbl[5] = '{addr: 8'h80, banks: {5'd0, 5'd1, 5'd2, 5'd3},
                   exp: {16'h0000, 16'h0000, 16'h0000, 16'h0001}};
        tbl[6] = '{addr: 8'h41, banks: {5'd1, 5'd1, 5'd0, 5'd1},
                   exp: {16'h00AA, 16'h00AA, 16'h0000, 16'h00AA}};

        rst = 1'b1; inc_valid = 1'b0; inc_bank = '0; inc_addr = '0;
        wr_valid = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0; rd_bank = '0; clr_start = 1'b0; clr_mask = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        chk("rst_clr_busy", {63'd0, clr_busy}, 64'd0);
        chk("rst_clr_done", {63'd0, clr_done}, 64'd0);
        chk("rst_sat_flag", {63'd0, sat_flag}, 64'd0);
        chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_inc_ready", {63'd0, inc_ready}, 64'd1);

        // 1: full clear
        clr_start = 1'b1; clr_mask = '1;
        step();
        clr_start = 1'b0; clr_mask = '0;
        chk("clr_busy_rise", {63'd0, clr_busy}, 64'd1);
        nb = 0; nd = 0; last_b = -1; done_i = -1;
        for (int i = 0; i < 600; i++) begin
            if (clr_busy) begin nb++; last_b = i; end
            if (clr_done) begin nd++; done_i = i; end
            step();
        end
        chk_range("clr_busy_cycles", nb, 256, 258);
        chk("clr_done_pulses", 64'(nd), 64'd1);
        chk("clr_done_after_busy", 64'(done_i), 64'(last_b + 1));
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < 256; a++) model[b][a] = '0;
        for (int a = 0; a < 256; a++)
            for (int g = 0; g < 8; g++)
                model_read(8'(a), 5'(4*g), 5'(4*g+1), 5'(4*g+2), 5'(4*g+3));
        rd_en = 1'b0;
        drain();

        // 2: back-to-back increments with forwarding
        for (int i = 0; i < 5; i++) inc(5'd3, 8'h7F);
        inc(5'd3, 8'h7F);
        inc(5'd3, 8'h80);
        inc(5'd3, 8'h7F);
        inc_valid = 1'b0;
        repeat (4) step();
        issue_read(8'h7F, {4{5'd3}}, {4{16'd7}});
        issue_read(8'h80, {4{5'd3}}, {4{16'd1}});
        rd_en = 1'b0;
        drain();

        // 3: saturation
        pb_write(5'd1, 8'd10, 16'hFFFE);
        step();
        chk("sat_before", {63'd0, sat_flag}, 64'd0);
        inc(5'd1, 8'd10);
        inc(5'd1, 8'd10);
        chk("sat_not_yet", {63'd0, sat_flag}, 64'd0);
        inc(5'd1, 8'd10);
        inc_valid = 1'b0;
        repeat (4) step();
        chk("sat_set", {63'd0, sat_flag}, 64'd1);
        issue_read(8'd10, {4{5'd1}}, {4{16'hFFFF}});
        rd_en = 1'b0;
        drain();

        // 4: tap table
        pb_write(5'd0, 8'h40, 16'h1111);
        pb_write(5'd5, 8'h40, 16'h2222);
        pb_write(5'd17, 8'h40, 16'h3333);
        pb_write(5'd31, 8'h40, 16'h4444);
        pb_write(5'd1, 8'h40, 16'h5555);
        pb_write(5'd1, 8'h41, 16'h00AA);
        step();
        last_exp = '0;
        for (int r = 0; r < 7; r++) begin
            issue_read(tbl[r].addr, tbl[r].banks, tbl[r].exp);
            last_exp = tbl[r].exp;
        end
        rd_en = 1'b0;
        drain();
        repeat (3) step();
        chk("rd_data_hold", rd_data, last_exp);
        chk("rd_valid_idle", {63'd0, rd_valid}, 64'd0);
        chk("sat_sticky", {63'd0, sat_flag}, 64'd1);

        // 5: clear bank 0 with increments in flight
        inc(5'd0, 8'h00);
        inc(5'd0, 8'h00);
        inc(5'd2, 8'h00);
        inc_bank = 5'd2; inc_addr = 8'h05;
        clr_start = 1'b1; clr_mask = 32'h0000_0001;
        #1;
        chk("inc_ready_clr_start", {63'd0, inc_ready}, 64'd0);
        step();
        clr_start = 1'b0; clr_mask = '0;
        chk("t5_clr_busy", {63'd0, clr_busy}, 64'd1);
        chk("sat_cleared", {63'd0, sat_flag}, 64'd0);
        seen = 0;
        for (int i = 0; i < 600; i++) begin
            if (clr_done) begin seen = 1; break; end
            step();
        end
        inc_valid = 1'b0;
        chk("t5_done_seen", 64'(seen), 64'd1);
        for (int a = 0; a < 256; a++) model[0][a] = '0;
        repeat (3) step();
        model_read(8'h00, 5'd0, 5'd0, 5'd2, 5'd2);
        model_read(8'h40, 5'd0, 5'd1, 5'd1, 5'd0);
        model_read(8'h41, 5'd1, 5'd0, 5'd1, 5'd0);
        model_read(8'h05, 5'd2, 5'd2, 5'd2, 5'd2);
        model_read(8'h7F, 5'd0, 5'd3, 5'd0, 5'd3);
        rd_en = 1'b0;
        drain();

        // 6: reset during clear
        pb_write(5'd4, 8'd200, 16'hBEEF);
        pb_write(5'd6, 8'd200, 16'hCAFE);
        pb_write(5'd4, 8'd50, 16'h1234);
        step();
        clr_start = 1'b1; clr_mask = '1;
        step();
        clr_start = 1'b0; clr_mask = '0;
        repeat (101) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_busy_after_rst", {63'd0, clr_busy}, 64'd0);
        nd = 0;
        for (int i = 0; i < 300; i++) begin
            if (clr_done) nd++;
            step();
        end
        chk("t6_no_done", 64'(nd), 64'd0);
        issue_read(8'd200, {5'd6, 5'd4, 5'd6, 5'd4}, {16'hCAFE, 16'hBEEF, 16'hCAFE, 16'hBEEF});
        issue_read(8'd50, {4{5'd4}}, 64'd0);
        rd_en = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
